// File: rtl/frame_peak_analyzer.sv
`default_nettype none
// ============================================================================
// frame_peak_analyzer : per-frame peak |sample|, peak index and sample sum
// Revision 1.0 - initial release
// ============================================================================
module frame_peak_analyzer #(
    parameter int WIDTH      = 36,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                buffer_ready_i,
    input  logic signed [WIDTH-1:0]             sample_data_i,
    input  logic                                sample_valid_i,
    output logic                                sample_ready_o,
    output logic                                result_valid_o,
    input  logic                                result_ready_i,
    output logic        [WIDTH-1:0]             peak_abs_o,
    output logic        [ADDR_WIDTH-1:0]        peak_index_o,
    output logic signed [WIDTH+ADDR_WIDTH-1:0]  sum_o,
    output logic        [7:0]                   frame_count_o,
    output logic                                overrun_o
);

    localparam int                    SUM_W    = WIDTH + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_RESULT  = 2'd2
    } state_t;

    state_t                    r_state;
    logic [ADDR_WIDTH-1:0]     r_count;
    logic [WIDTH-1:0]          r_peak;
    logic [ADDR_WIDTH-1:0]     r_idx;
    logic signed [SUM_W-1:0]   r_sum;

    logic                      w_accept;
    logic [WIDTH-1:0]          w_raw;
    logic [WIDTH-1:0]          w_abs;
    logic                      w_gt;
    logic [WIDTH-1:0]          w_peak_nxt;
    logic [ADDR_WIDTH-1:0]     w_idx_nxt;
    logic signed [SUM_W-1:0]   w_sum_nxt;

    assign sample_ready_o = (r_state == S_COLLECT);
    assign result_valid_o = (r_state == S_RESULT);
    assign w_accept       = sample_valid_i && sample_ready_o;

    // Two's-complement negate in WIDTH bits: the most negative value maps to 2^(WIDTH-1).
    assign w_raw      = $unsigned(sample_data_i);
    assign w_abs      = sample_data_i[WIDTH-1] ? (~w_raw + 1'b1) : w_raw;
    assign w_gt       = (w_abs > r_peak);
    assign w_peak_nxt = w_gt ? w_abs : r_peak;
    assign w_idx_nxt  = w_gt ? r_count : r_idx;
    assign w_sum_nxt  = r_sum + {{ADDR_WIDTH{sample_data_i[WIDTH-1]}}, sample_data_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_peak        <= '0;
            r_idx         <= '0;
            r_sum         <= '0;
            peak_abs_o    <= '0;
            peak_index_o  <= '0;
            sum_o         <= '0;
            frame_count_o <= '0;
            overrun_o     <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (buffer_ready_i) begin
                        r_state <= S_COLLECT;
                        r_count <= '0;
                        r_peak  <= '0;
                        r_idx   <= '0;
                        r_sum   <= '0;
                    end
                end
                S_COLLECT: begin
                    // A new frame arriving mid-collection wins over any sample this cycle.
                    if (buffer_ready_i) begin
                        overrun_o <= 1'b1;
                        r_count   <= '0;
                        r_peak    <= '0;
                        r_idx     <= '0;
                        r_sum     <= '0;
                    end else if (w_accept) begin
                        r_count <= r_count + 1'b1;
                        r_peak  <= w_peak_nxt;
                        r_idx   <= w_idx_nxt;
                        r_sum   <= w_sum_nxt;
                        if (r_count == LAST_IDX) begin
                            peak_abs_o    <= w_peak_nxt;
                            peak_index_o  <= w_idx_nxt;
                            sum_o         <= w_sum_nxt;
                            frame_count_o <= frame_count_o + 8'd1;
                            r_state       <= S_RESULT;
                        end
                    end
                end
                S_RESULT: begin
                    if (result_ready_i) begin
                        if (buffer_ready_i) begin
                            r_state <= S_COLLECT;
                            r_count <= '0;
                            r_peak  <= '0;
                            r_idx   <= '0;
                            r_sum   <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (buffer_ready_i) begin
                        overrun_o <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_peak_analyzer.sv
`default_nettype none
// ============================================================================
// tb_frame_peak_analyzer : scoreboard bench for frame_peak_analyzer
// Revision 1.0 - initial release
// ============================================================================
module tb_frame_peak_analyzer;

    localparam int W  = 36;
    localparam int D  = 16;
    localparam int A  = 4;
    localparam int SW = W + A;

    logic                 clk;
    logic                 rst_i;
    logic                 buffer_ready_i;
    logic signed [W-1:0]  sample_data_i;
    logic                 sample_valid_i;
    logic                 sample_ready_o;
    logic                 result_valid_o;
    logic                 result_ready_i;
    logic [W-1:0]         peak_abs_o;
    logic [A-1:0]         peak_index_o;
    logic signed [SW-1:0] sum_o;
    logic [7:0]           frame_count_o;
    logic                 overrun_o;

    frame_peak_analyzer #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(A)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .buffer_ready_i (buffer_ready_i),
        .sample_data_i  (sample_data_i),
        .sample_valid_i (sample_valid_i),
        .sample_ready_o (sample_ready_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .peak_abs_o     (peak_abs_o),
        .peak_index_o   (peak_index_o),
        .sum_o          (sum_o),
        .frame_count_o  (frame_count_o),
        .overrun_o      (overrun_o)
    );

    typedef struct {
        logic [W-1:0]         peak;
        logic [A-1:0]         idx;
        logic signed [SW-1:0] sum;
        logic [7:0]           fc;
    } exp_t;

    exp_t                sb[$];
    exp_t                mon_e;
    int                  total  = 0;
    int                  bad    = 0;
    int                  ov_cnt = 0;
    logic signed [W-1:0] fr[D];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] p, input logic [A-1:0] i,
                                input logic signed [SW-1:0] s, input logic [7:0] f);
        exp_t e;
        e.peak = p; e.idx = i; e.sum = s; e.fc = f;
        return e;
    endfunction

    // Monitor: pops the scoreboard on every result handshake.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (overrun_o) ov_cnt++;
            if (result_valid_o && result_ready_i) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got peak %0h with empty scoreboard", peak_abs_o);
                end else begin
                    mon_e = sb.pop_front();
                    check("peak_abs",    64'(peak_abs_o),    64'(mon_e.peak));
                    check("peak_index",  64'(peak_index_o),  64'(mon_e.idx));
                    check("sum",         64'(sum_o),         64'(mon_e.sum));
                    check("frame_count", 64'(frame_count_o), 64'(mon_e.fc));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_br();
        buffer_ready_i = 1'b1;
        tick();
        buffer_ready_i = 1'b0;
    endtask

    task automatic drive_sample(input logic signed [W-1:0] v);
        int n;
        n = 0;
        sample_valid_i = 1'b1;
        sample_data_i  = v;
        while (!sample_ready_o && n < 20) begin
            tick();
            n++;
        end
        if (!sample_ready_o) check("sample_ready_timeout", 64'(sample_ready_o), 64'd1);
        tick();
    endtask

    task automatic send_frame(input exp_t e);
        sb.push_back(e);
        for (int i = 0; i < D; i++) begin
            if (i == D - 1) check("valid_before_last", 64'(result_valid_o), 64'd0);
            drive_sample(fr[i]);
        end
        sample_valid_i = 1'b0;
        check("valid_after_last", 64'(result_valid_o), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ov0;
        rst_i          = 1'b1;
        buffer_ready_i = 1'b0;
        sample_valid_i = 1'b0;
        sample_data_i  = '0;
        result_ready_i = 1'b1;
        tick();
        tick();
        check("rst_ready",   64'(sample_ready_o), 64'd0);
        check("rst_valid",   64'(result_valid_o), 64'd0);
        check("rst_peak",    64'(peak_abs_o),     64'd0);
        check("rst_sum",     64'(sum_o),          64'd0);
        check("rst_fc",      64'(frame_count_o),  64'd0);
        rst_i = 1'b0;
        tick();

        // Ramp 0..15
        for (int i = 0; i < D; i++) fr[i] = W'(i);
        pulse_br();
        send_frame(mk(36'd15, 4'd15, 40'sd120, 8'd1));
        tick();

        // Extremes
        for (int i = 0; i < D; i++) fr[i] = '0;
        fr[3] = 36'sh800000000;
        fr[5] = 36'sh7FFFFFFFF;
        pulse_br();
        send_frame(mk(36'h800000000, 4'd3, -40'sd1, 8'd2));
        tick();

        // Ties: first occurrence wins
        for (int i = 0; i < D; i++) fr[i] = 36'sd1;
        fr[2] = 36'sd7;
        fr[9] = -36'sd7;
        pulse_br();
        send_frame(mk(36'd7, 4'd2, 40'sd14, 8'd3));
        tick();

        // All-zero frame
        for (int i = 0; i < D; i++) fr[i] = '0;
        pulse_br();
        send_frame(mk(36'd0, 4'd0, 40'sd0, 8'd4));
        tick();

        // Restart mid-collection; the sample offered with the restart is dropped
        pulse_br();
        for (int i = 0; i < 5; i++) drive_sample(36'sd9);
        ov0            = ov_cnt;
        sample_data_i  = 36'sd100;
        buffer_ready_i = 1'b1;
        tick();
        buffer_ready_i = 1'b0;
        sample_valid_i = 1'b0;
        check("restart_overrun", 64'(overrun_o), 64'd1);
        tick();
        check("restart_overrun_1cyc", 64'(overrun_o), 64'd0);
        check("restart_overrun_cnt", 64'(ov_cnt), 64'(ov0 + 1));
        for (int i = 0; i < D; i++) fr[i] = 36'sd2;
        send_frame(mk(36'd2, 4'd0, 40'sd32, 8'd5));
        tick();

        // Backpressure with a skipped frame
        result_ready_i = 1'b0;
        for (int i = 0; i < D; i++) fr[i] = W'(-i);
        pulse_br();
        send_frame(mk(36'd15, 4'd15, -40'sd120, 8'd6));
        ov0 = ov_cnt;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) buffer_ready_i = 1'b1;
            tick();
            buffer_ready_i = 1'b0;
            if (c == 3) check("bp_overrun", 64'(overrun_o), 64'd1);
            check("bp_valid", 64'(result_valid_o), 64'd1);
            check("bp_peak",  64'(peak_abs_o),     64'd15);
            check("bp_idx",   64'(peak_index_o),   64'd15);
            check("bp_sum",   64'(sum_o),          64'(-40'sd120));
            check("bp_fc",    64'(frame_count_o),  64'd6);
        end
        check("bp_overrun_cnt", 64'(ov_cnt), 64'(ov0 + 1));
        result_ready_i = 1'b1;
        tick();
        check("bp_idle_valid", 64'(result_valid_o), 64'd0);
        sample_valid_i = 1'b1;
        sample_data_i  = 36'sd55;
        tick();
        tick();
        check("bp_idle_ready", 64'(sample_ready_o), 64'd0);
        sample_valid_i = 1'b0;

        // Handshake and new buffer in the same cycle: straight to COLLECT
        for (int i = 0; i < D; i++) fr[i] = 36'sd5;
        pulse_br();
        send_frame(mk(36'd5, 4'd0, 40'sd80, 8'd7));
        ov0 = ov_cnt;
        pulse_br();
        check("hs_br_no_overrun", 64'(overrun_o), 64'd0);
        check("hs_br_collect",    64'(sample_ready_o), 64'd1);
        for (int i = 0; i < D; i++) fr[i] = 36'sd3;
        send_frame(mk(36'd3, 4'd0, 40'sd48, 8'd8));
        check("hs_br_ov_cnt", 64'(ov_cnt), 64'(ov0));
        tick();

        // Reset held 2 cycles mid-collection
        pulse_br();
        for (int i = 0; i < 3; i++) drive_sample(36'sd50);
        sample_valid_i = 1'b0;
        rst_i = 1'b1;
        tick();
        tick();
        check("mid_rst_ready", 64'(sample_ready_o), 64'd0);
        check("mid_rst_valid", 64'(result_valid_o), 64'd0);
        check("mid_rst_peak",  64'(peak_abs_o),     64'd0);
        check("mid_rst_idx",   64'(peak_index_o),   64'd0);
        check("mid_rst_sum",   64'(sum_o),          64'd0);
        check("mid_rst_fc",    64'(frame_count_o),  64'd0);
        check("mid_rst_ov",    64'(overrun_o),      64'd0);
        rst_i = 1'b0;
        sample_valid_i = 1'b1;
        sample_data_i  = 36'sd77;
        tick();
        tick();
        check("post_rst_ready", 64'(sample_ready_o), 64'd0);
        sample_valid_i = 1'b0;
        for (int i = 0; i < D; i++) fr[i] = W'(i);
        pulse_br();
        send_frame(mk(36'd15, 4'd15, 40'sd120, 8'd1));
        tick();
        tick();

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
